mm3_ctrl: RTL
=============

Name: mm3_ctrl

Overview:
- Flow-control wrapper and scheduler for the fixed-latency 3-term FP dot-product datapath (three fpu_mul feeding a two-level fpu_add tree).
- The datapath has no valid or stall signals, so this block supplies them:
  - accepts operand sets through a valid/ready handshake;
  - registers them into the datapath;
  - tracks in-flight issues with a valid/tag shift line;
  - captures results into an output FIFO.
- Credit control guarantees the FIFO can never overflow, so the datapath never needs to stall.

Parameters:
- BITS, 32, operand/result width.
- LATENCY, 13, cycles from dp_* operand register edge to dp_result valid (set to the datapath's total pipeline depth).
- FIFO_DEPTH, 16, result FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept this cycle.
- in_a1, in_a2, in_a3, in_b1, in_b2, in_b3  input  BITS each  operands.
- in_tag  input  TAG_W  user tag.
- dp_a1, dp_a2, dp_a3, dp_b1, dp_b2, dp_b3  output  BITS each  registered operands to datapath.
- dp_result  input  BITS  datapath output.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts.
- out_data  output  BITS  result at FIFO head.
- out_tag  output  TAG_W  tag at FIFO head.
- busy  output  1  any op in flight or buffered.

Behaviour:
- Definitions:
  - fire = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Cycle T = fire cycle.
- in_ready = (inflight_cnt + fifo_cnt) < FIFO_DEPTH.
  - Both counters are registers, so in_ready never depends on in_valid or out_ready in the same cycle.
- Operand issue:
  - On fire: dp_* <= in_* at edge T.
  - Otherwise dp_* <= 0 (quiesces the datapath; zero products are harmless).
- Shift line:
  - LATENCY stages of {vld, tag}.
  - Stage 0 <= {fire, in_tag} at edge T.
  - When the last stage holds vld=1, dp_result is valid that cycle and is written into the FIFO with its tag.
- Latency: with an empty FIFO, out_valid rises in cycle T+LATENCY+1 with the result of the op accepted at T.
- Throughput: one op per cycle while credits remain.
- Counters:
  - inflight_cnt: +1 on fire, −1 on shift-line exit.
  - fifo_cnt: +1 on exit write, −1 on pop.
  - Simultaneous increment and decrement leave the value unchanged.
  - Credit freed by a pop is visible in in_ready the following cycle.
- FIFO:
  - First-word-fall-through; out_data/out_tag are valid whenever out_valid=1.
  - Order is strictly issue order.
  - Simultaneous write and pop allowed at any occupancy, including full (credit prevents an actual write-when-full) and empty (an exiting result is presented the following cycle, never bypassed).
  - Read/write pointers wrap modulo FIFO_DEPTH.
- busy = (inflight_cnt != 0) | (fifo_cnt != 0).
- Reset (any time, including mid-operation):
  - Clears the shift line, counters and FIFO pointers.
  - dp_* = 0, out_valid = 0, in_ready = 1 from the first cycle after reset, busy = 0.
  - In-flight results are discarded; garbage emerging from the datapath after reset is ignored because all vld bits are cleared.
- Illegal parameters (LATENCY < 1, FIFO_DEPTH non-power-of-two): elaboration error.

Optional Feature:
- Macro: MM3_CTRL_PERF_EN.
- Defined: adds three 32-bit output counters, cleared by reset and saturating at all-ones:
  - perf_issued: fire count.
  - perf_completed: pop count.
  - perf_stall: cycles with in_valid & ~in_ready.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mm3_ctrl_pkg:
  - Default constants for BITS, LATENCY, TAG_W and FIFO_DEPTH.
  - Typedef for the {vld, tag} shift-line entry.
  - Typedef for the FIFO entry {data, tag}.
- Sub-module mm3_ctrl_fifo:
  - Parameterised synchronous FWFT FIFO with count output.
  - Instantiated once.
- The shift line and credit logic remain in mm3_ctrl.

Test Plan (bench uses LATENCY=4, FIFO_DEPTH=4, datapath model = exact 4-cycle delay line of a1*b1+a2*b2+a3*b3):
- Single op: a=(1.0,2.0,3.0), b=(4.0,5.0,6.0), tag=3, fire at T → out_valid in T+5, out_data=0x42000000 (32.0), out_tag=3; busy falls after pop.
- Back-to-back: 4 ops with tags 0..3 on consecutive cycles, out_ready=1 → results arrive on 4 consecutive cycles in tag order; in_ready stays 1 throughout.
- Backpressure: out_ready=0, in_valid=1 held → exactly 4 fires, then in_ready=0 and perf_stall increments each cycle; after one pop, in_ready=1 on the next cycle and exactly one more fire occurs.
- Simultaneous: FIFO holding 2 entries, one result exiting while pop occurs → fifo_cnt stays 2; order preserved.
- Reset mid-flight: 3 ops in flight, reset for 1 cycle → no out_valid for 10 cycles afterwards despite nonzero dp_result; in_ready=1; busy=0.
- Wrap-around: 11 ops with random out_ready → all 11 results match the model in order; pointers wrap at least twice.

Source files
------------

// File: rtl/mm3_ctrl_pkg.sv
// mm3_ctrl_pkg: shared constants and payload types for the mm3 dot-product
// flow-control wrapper.
//   - Default BITS / LATENCY / FIFO_DEPTH / TAG_W values.
//   - The shift-line entry, FIFO entry and operand-set payload structs.
//     These are sized from the package widths, so a build that uses them
//     runs with BITS = MM3_BITS and TAG_W = MM3_TAG_W.
package mm3_ctrl_pkg;

  localparam int unsigned MM3_BITS       = 32;
  localparam int unsigned MM3_LATENCY    = 13;
  localparam int unsigned MM3_FIFO_DEPTH = 16;
  localparam int unsigned MM3_TAG_W      = 4;
  localparam int unsigned MM3_PERF_W     = 32;

  // One stage of the in-flight tracking line.
  typedef struct packed {
    logic                 vld;
    logic [MM3_TAG_W-1:0] tag;
  } sl_entry_t;

  // One buffered result.
  typedef struct packed {
    logic [MM3_BITS-1:0]  data;
    logic [MM3_TAG_W-1:0] tag;
  } fifo_entry_t;

  // Operand set presented to the datapath.
  typedef struct packed {
    logic [MM3_BITS-1:0] a1;
    logic [MM3_BITS-1:0] a2;
    logic [MM3_BITS-1:0] a3;
    logic [MM3_BITS-1:0] b1;
    logic [MM3_BITS-1:0] b2;
    logic [MM3_BITS-1:0] b3;
  } op_set_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mm3_ctrl_fifo.sv
// mm3_ctrl_fifo: synchronous first-word-fall-through result FIFO.
//   clock, reset   : clock and synchronous active-high reset
//   wr_en, wr_data : push an entry (caller guarantees not full)
//   rd_en          : pop the head (caller guarantees not empty)
//   rd_data_c      : head entry, valid whenever count != 0
//   count          : current occupancy (registered)
// Pointers are log2(DEPTH) bits wide so they wrap modulo DEPTH for free.
module mm3_ctrl_fifo
  import mm3_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = MM3_FIFO_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  fifo_entry_t      wr_data,
  input  logic             rd_en,
  output fifo_entry_t      rd_data_c,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointer / occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the count qualifies every read.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign count     = cnt_q;

endmodule

// File: rtl/mm3_ctrl.sv
// mm3_ctrl: flow-control wrapper for the fixed-latency 3-term FP dot-product
// datapath. Accepts operand sets on a valid/ready handshake, registers them
// into the datapath, tracks in-flight ops on a {vld, tag} shift line and
// captures results into a FWFT FIFO. Credits (in flight + buffered <=
// FIFO_DEPTH) guarantee the FIFO never overflows, so the datapath never stalls.
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_a*/in_b*/in_tag payload
//   dp_a*/dp_b*           : registered operands to the datapath (0 when idle)
//   dp_result             : datapath output, LATENCY cycles after dp_* edge
//   out_valid/out_ready   : result handshake; out_data/out_tag at FIFO head
//   busy                  : anything in flight or buffered
// Optional: define MM3_CTRL_PERF_EN to add perf_issued, perf_completed and
// perf_stall saturating 32-bit counters.
module mm3_ctrl
  import mm3_ctrl_pkg::*;
#(
  parameter int unsigned BITS       = MM3_BITS,
  parameter int unsigned LATENCY    = MM3_LATENCY,
  parameter int unsigned FIFO_DEPTH = MM3_FIFO_DEPTH,
  parameter int unsigned TAG_W      = MM3_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_a1,
  input  logic [BITS-1:0]  in_a2,
  input  logic [BITS-1:0]  in_a3,
  input  logic [BITS-1:0]  in_b1,
  input  logic [BITS-1:0]  in_b2,
  input  logic [BITS-1:0]  in_b3,
  input  logic [TAG_W-1:0] in_tag,
  output logic [BITS-1:0]  dp_a1,
  output logic [BITS-1:0]  dp_a2,
  output logic [BITS-1:0]  dp_a3,
  output logic [BITS-1:0]  dp_b1,
  output logic [BITS-1:0]  dp_b2,
  output logic [BITS-1:0]  dp_b3,
  input  logic [BITS-1:0]  dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
`ifdef MM3_CTRL_PERF_EN
  output logic [MM3_PERF_W-1:0] perf_issued,
  output logic [MM3_PERF_W-1:0] perf_completed,
  output logic [MM3_PERF_W-1:0] perf_stall,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Elaboration-time parameter guards.
  if (LATENCY == 0) begin : g_bad_latency
    $error("mm3_ctrl: LATENCY must be >= 1");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
    $error("mm3_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BITS != MM3_BITS || TAG_W != MM3_TAG_W) begin : g_bad_width
    $error("mm3_ctrl: BITS/TAG_W must match the mm3_ctrl_pkg payload widths");
  end

  logic             fire;
  logic             pop;
  logic             sl_exit;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   credit_used;
  fifo_entry_t      fifo_wr;
  fifo_entry_t      fifo_head;

  sl_entry_t        sl_q [LATENCY];
  sl_entry_t        sl_d [LATENCY];
  op_set_t          dp_q, dp_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign in_ready    = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
  assign fire        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign sl_exit     = sl_q[LATENCY-1].vld;

  // Operand issue, shift-line advance and in-flight accounting.
  always_comb begin
    dp_d = '0;
    if (fire) begin
      dp_d = '{a1: in_a1, a2: in_a2, a3: in_a3, b1: in_b1, b2: in_b2, b3: in_b3};
    end
    sl_d[0] = '{vld: fire, tag: in_tag};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      sl_d[i] = sl_q[i-1];
    end
    inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(sl_exit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dp_q       <= '0;
      inflight_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        sl_q[i] <= '0;
      end
    end else begin
      dp_q       <= dp_d;
      inflight_q <= inflight_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        sl_q[i] <= sl_d[i];
      end
    end
  end

  assign dp_a1 = dp_q.a1;
  assign dp_a2 = dp_q.a2;
  assign dp_a3 = dp_q.a3;
  assign dp_b1 = dp_q.b1;
  assign dp_b2 = dp_q.b2;
  assign dp_b3 = dp_q.b3;

  // Result capture: the exiting shift-line entry qualifies dp_result.
  assign fifo_wr = '{data: dp_result, tag: sl_q[LATENCY-1].tag};

  mm3_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (sl_exit),
    .wr_data   (fifo_wr),
    .rd_en     (pop),
    .rd_data_c (fifo_head),
    .count     (fifo_cnt)
  );

  assign out_valid = fifo_cnt != '0;
  assign out_data  = fifo_head.data;
  assign out_tag   = fifo_head.tag;
  assign busy      = (inflight_q != '0) | (fifo_cnt != '0);

`ifdef MM3_CTRL_PERF_EN
  logic [MM3_PERF_W-1:0] perf_issued_q, perf_issued_d;
  logic [MM3_PERF_W-1:0] perf_completed_q, perf_completed_d;
  logic [MM3_PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Saturating event counters.
  always_comb begin
    perf_issued_d    = perf_issued_q;
    perf_completed_d = perf_completed_q;
    perf_stall_d     = perf_stall_q;
    if (fire && perf_issued_q != '1) begin
      perf_issued_d = perf_issued_q + MM3_PERF_W'(1);
    end
    if (pop && perf_completed_q != '1) begin
      perf_completed_d = perf_completed_q + MM3_PERF_W'(1);
    end
    if (in_valid && !in_ready && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + MM3_PERF_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issued_q    <= '0;
      perf_completed_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      perf_issued_q    <= perf_issued_d;
      perf_completed_q <= perf_completed_d;
      perf_stall_q     <= perf_stall_d;
    end
  end

  assign perf_issued    = perf_issued_q;
  assign perf_completed = perf_completed_q;
  assign perf_stall     = perf_stall_q;
`endif

endmodule
